lsu_seq: RTL and testbench
==========================

LSU_SEQ -- requirements
Module: lsu_seq

Interface
REQ-001 SHALL have parameter: none; DMType codes use the codebase macros dm_word, dm_halfword, dm_halfword_unsigned, dm_byte, dm_byte_unsigned.
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on posedge.
REQ-003 SHALL have port: rstn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req  in  1  core access request, sampled only in IDLE.
REQ-005 SHALL have port: we  in  1  1=store, 0=load.
REQ-006 SHALL have port: type  in  3  DMType code of access.
REQ-007 SHALL have port: addr  in  32  byte address.
REQ-008 SHALL have port: wdata  in  32  store data, LSB-aligned.
REQ-009 SHALL have port: pc  in  32  pc of the issuing instruction.
REQ-010 SHALL have port: busy  out  1  high whenever state is not IDLE.
REQ-011 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: err  out  1  valid with done; 1=access rejected.
REQ-013 SHALL have port: rdata  out  32  load result, valid with done.
REQ-014 SHALL have ports to data memory: dm_wr out 1, dm_type out 3, dm_addr out 30 (bits [31:2]), dm_din out 32, dm_pc out 32, dm_dout in 32.

Function
REQ-015 SHALL implement FSM IDLE -> BEAT -> FINISH -> IDLE; req with IDLE at posedge latches we/type/addr/wdata/pc and enters BEAT.
REQ-016 SHALL classify misaligned: halfword types with addr[0]=1; dm_word with addr[1:0]!=0; byte types never.
REQ-017 SHALL issue k beats in BEAT: k=1 for aligned, k=2 for misaligned halfword, k=4 for misaligned word; beat counter 2 bits, BEAT->FINISH after beat k-1.
REQ-018 SHALL for aligned beat drive dm_type=latched type, dm_addr={2'b00, addr[31:4], addr[3:2]}... defined as dm_addr[31:2] carrying byte address bits [29:0], dm_din=wdata.
REQ-019 SHALL for split beat i drive dm_type=dm_byte (store) or dm_byte_unsigned (load), byte address addr+i, dm_din[7:0]=wdata byte i.
REQ-020 SHALL assert dm_wr only in BEAT with we=1; dm_wr=0 in IDLE/FINISH and for loads.
REQ-021 SHALL capture dm_dout at end of each load beat; split loads assemble little-endian (beat i -> byte i), then sign-extend (dm_halfword, dm_word n/a) or zero-extend (dm_halfword_unsigned) per original type.
REQ-022 SHALL pulse done=1 in FINISH only, with rdata and err stable that cycle; for stores rdata=0.
REQ-023 SHALL give latency: req accepted at edge N -> beats in cycles N+1..N+k -> done in cycle N+1+k -> IDLE at N+2+k.
REQ-024 SHALL ignore req while busy=1 (no queueing); req in FINISH ignored.
REQ-025 SHALL treat unknown type codes as err=1: zero beats, BEAT skipped, FINISH at N+1, no dm_wr.
REQ-026 SHALL drive dm_pc=latched pc in all states.
REQ-027 SHALL wrap byte address addr+i modulo 2^32.

Reset
REQ-028 SHALL on rstn=0 at posedge: state IDLE, beat counter 0, busy=0, done=0, err=0, rdata=0, dm_wr=0, latched regs 0.
REQ-029 SHALL on reset mid-BEAT abort; bytes already written remain in memory; no done pulse.

Configuration
REQ-030 SHALL support macro MISALIGN_TRAP_EN: defined -> misaligned accesses get zero beats, err=1, done at N+1, no dm_wr; undefined -> misaligned accesses split per REQ-017..REQ-021, err=0.

Verification
REQ-031 SHALL cover: aligned store dm_word addr=0x10 wdata=0xA1B2C3D4 -> one beat, dm_wr=1 once, done at N+2, err=0.
REQ-032 SHALL cover: mem bytes 0x11..0x14 at 0x21..0x24 = 11,22,33,84; load dm_word addr=0x21 -> 4 beats, done at N+5, rdata=0x84332211 (macro undefined).
REQ-033 SHALL cover: load dm_halfword addr=0x23 bytes 0x00,0x80 -> rdata=0xFFFF8000; dm_halfword_unsigned -> 0x00008000.
REQ-034 SHALL cover: MISALIGN_TRAP_EN defined, store dm_word addr=0x22 -> done at N+1, err=1, dm_wr never high, memory unchanged.
REQ-035 SHALL cover: rstn=0 during beat 2 of 4-beat store -> bytes 0,1 written, no done, busy=0 next cycle; req during busy ignored.

Source files
------------

// File: rtl/lsu_seq.sv
// lsu_seq -- sequential load/store unit between the core and data memory.
//
// One access at a time: IDLE -> BEAT (k beats) -> FINISH -> IDLE.
// Misaligned halfword/word accesses are split into single-byte beats
// (little-endian). Unknown access types are rejected with err=1.
//
// Build option:
//   MISALIGN_TRAP_EN  defined   -> misaligned accesses are rejected (err=1,
//                                  no beats, no memory write).
//                     undefined -> misaligned accesses are split into bytes.
//
// The access-type input is named dmtype because `type` is a reserved word.
// dm_addr carries byte-address bits [29:0] so the memory sees the byte lane.

`ifndef DM_WORD
`define DM_WORD              3'b000
`endif
`ifndef DM_HALFWORD
`define DM_HALFWORD          3'b001
`endif
`ifndef DM_HALFWORD_UNSIGNED
`define DM_HALFWORD_UNSIGNED 3'b010
`endif
`ifndef DM_BYTE
`define DM_BYTE              3'b011
`endif
`ifndef DM_BYTE_UNSIGNED
`define DM_BYTE_UNSIGNED     3'b100
`endif

module lsu_seq (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  dmtype,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        dm_wr,
    output logic [2:0]  dm_type,
    output logic [29:0] dm_addr,
    output logic [31:0] dm_din,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BEAT   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    // Request latched at acceptance
    logic        we_q;
    logic [2:0]  type_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;

    // Beat bookkeeping
    logic [1:0]  cnt;       // current beat index
    logic [1:0]  last_q;    // index of the final beat (k-1)
    logic        split_q;   // access is being issued as byte beats
    logic        err_q;     // access was rejected

    // Load data collected over the beats
    logic [31:0] buf_q;

    // Classification of the request currently on the input pins
    logic        known_in;
    logic        misal_in;
    logic        reject_in;
    logic        split_in;
    logic [1:0]  last_in;

    // Extended load result
    logic [31:0] load_val;

    // Classify the incoming request: known type, misalignment, beat count
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        known_in = 1'b1;
        misal_in = 1'b0;
        last_in  = 2'd0;
        case (dmtype)
            `DM_WORD: begin
                misal_in = (addr[1:0] != 2'b00);
                last_in  = misal_in ? 2'd3 : 2'd0;
            end
            `DM_HALFWORD, `DM_HALFWORD_UNSIGNED: begin
                misal_in = addr[0];
                last_in  = misal_in ? 2'd1 : 2'd0;
            end
            `DM_BYTE, `DM_BYTE_UNSIGNED: begin
                misal_in = 1'b0;
                last_in  = 2'd0;
            end
            default: known_in = 1'b0;
        endcase
`ifdef MISALIGN_TRAP_EN
        reject_in = !known_in || misal_in;
`else
        reject_in = !known_in;
`endif
        split_in = misal_in && !reject_in;
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and memory-side / core-side outputs
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == FINISH);
        err      = (state == FINISH) && err_q;
        rdata    = 32'd0;
        dm_wr    = 1'b0;
        dm_type  = type_q;
        dm_addr  = addr_q[29:0];
        dm_din   = wdata_q;
        dm_pc    = pc_q;

        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = reject_in ? FINISH : BEAT;
                end
            end
            BEAT: begin
                dm_wr = we_q;
                if (split_q) begin
                    dm_type = we_q ? `DM_BYTE : `DM_BYTE_UNSIGNED;
                    // Byte address addr+i wraps modulo 2^32; only bits [29:0] leave.
                    dm_addr = 30'(addr_q + {30'd0, cnt});
                    dm_din  = {24'd0, wdata_q[{cnt, 3'b000} +: 8]};
                end
                if (cnt == last_q) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                if (!we_q && !err_q) begin
                    rdata = load_val;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Extend a byte-assembled load according to the original access type
    always_comb begin
        load_val = buf_q;
        if (split_q) begin
            case (type_q)
                `DM_HALFWORD:          load_val = {{16{buf_q[15]}}, buf_q[15:0]};
                `DM_HALFWORD_UNSIGNED: load_val = {16'd0, buf_q[15:0]};
                default:               load_val = buf_q;
            endcase
        end
    end

    // Request latch, beat counter and load-data capture
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too, because rdata, dm_pc and
        // the latched request must read as zero straight after reset.
        if (!rstn) begin
            we_q    <= 1'b0;
            type_q  <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            cnt     <= 2'd0;
            last_q  <= 2'd0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            buf_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        type_q  <= dmtype;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        pc_q    <= pc;
                        cnt     <= 2'd0;
                        last_q  <= last_in;
                        split_q <= split_in;
                        err_q   <= reject_in;
                        buf_q   <= 32'd0;
                    end
                end
                BEAT: begin
                    cnt <= cnt + 2'd1;
                    if (!we_q) begin
                        if (split_q) begin
                            buf_q[{cnt, 3'b000} +: 8] <= dm_dout[7:0];
                        end else begin
                            buf_q <= dm_dout;
                        end
                    end
                end
                default: begin
                    cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq -- self-checking bench for lsu_seq with a byte-addressed memory
// model and a scoreboard of expected completions (rdata, err, latency, writes).

`ifndef DM_WORD
`define DM_WORD              3'b000
`endif
`ifndef DM_HALFWORD
`define DM_HALFWORD          3'b001
`endif
`ifndef DM_HALFWORD_UNSIGNED
`define DM_HALFWORD_UNSIGNED 3'b010
`endif
`ifndef DM_BYTE
`define DM_BYTE              3'b011
`endif
`ifndef DM_BYTE_UNSIGNED
`define DM_BYTE_UNSIGNED     3'b100
`endif

module tb_lsu_seq;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic        we;
    logic [2:0]  dmtype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        dm_wr;
    logic [2:0]  dm_type;
    logic [29:0] dm_addr;
    logic [31:0] dm_din;
    logic [31:0] dm_pc;
    logic [31:0] dm_dout;

    lsu_seq dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .we      (we),
        .dmtype  (dmtype),
        .addr    (addr),
        .wdata   (wdata),
        .pc      (pc),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .dm_wr   (dm_wr),
        .dm_type (dm_type),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_pc   (dm_pc),
        .dm_dout (dm_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- memory model (256 bytes, byte-addressed) -------------
    logic [7:0] mem [0:255] = '{default: 8'h00};
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;
    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        a0 = dm_addr[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        dm_dout = 32'd0;
        case (dm_type)
            `DM_WORD:              dm_dout = {mem[a3], mem[a2], mem[a1], mem[a0]};
            `DM_HALFWORD:          dm_dout = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            `DM_HALFWORD_UNSIGNED: dm_dout = {16'd0, mem[a1], mem[a0]};
            `DM_BYTE:              dm_dout = {{24{mem[a0][7]}}, mem[a0]};
            `DM_BYTE_UNSIGNED:     dm_dout = {24'd0, mem[a0]};
            default:               dm_dout = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (dm_wr === 1'b1) begin
            case (dm_type)
                `DM_WORD: begin
                    mem[a0] <= dm_din[7:0];   mem[a1] <= dm_din[15:8];
                    mem[a2] <= dm_din[23:16]; mem[a3] <= dm_din[31:24];
                end
                `DM_HALFWORD, `DM_HALFWORD_UNSIGNED: begin
                    mem[a0] <= dm_din[7:0];   mem[a1] <= dm_din[15:8];
                end
                default: mem[a0] <= dm_din[7:0];
            endcase
        end
    end

    // ---------------- scoreboard and monitor -------------------------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wrs;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          wr_cnt = 0;
    logic [31:0] cur_pc = 32'd0;

    always @(negedge clk) begin
        if (dm_wr === 1'b1) wr_cnt++;
        if (busy === 1'b1) begin
            n_cmp++;
            if (dm_pc !== cur_pc) begin
                n_bad++;
                $display("FAIL dm_pc: got %h want %h (cyc %0d)", dm_pc, cur_pc, cyc);
            end
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 with no access outstanding (cyc %0d)", cyc);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL rdata: got %h want %h", rdata, e.rdata);
                end
                n_cmp++;
                if (err !== e.err) begin
                    n_bad++;
                    $display("FAIL err: got %b want %b", err, e.err);
                end
                n_cmp++;
                if (cyc - e.acc !== e.lat) begin
                    n_bad++;
                    $display("FAIL latency: done %0d cycles after accept, want %0d", cyc - e.acc, e.lat);
                end
                n_cmp++;
                if (wr_cnt !== e.wrs) begin
                    n_bad++;
                    $display("FAIL dm_wr_count: got %0d want %0d", wr_cnt, e.wrs);
                end
            end
            wr_cnt = 0;
        end else if (busy !== 1'b1) begin
            wr_cnt = 0;
        end
    end

    // ---------------- driver helpers ---------------------------------------
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p,
                         input logic [31:0] x_rd, input logic x_err,
                         input int x_lat, input int x_wrs, input bit track);
        exp_t x;
        int   guard = 0;
        @(negedge clk);
        while (busy !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: busy stuck at %b", busy);
        end
        req    = 1'b1;
        we     = w;
        dmtype = t;
        addr   = a;
        wdata  = d;
        pc     = p;
        cur_pc = p;
        @(posedge clk);
        #1;
        req = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_busy: got %b want 1", busy);
        end
        if (track) begin
            x.rdata = x_rd;
            x.err   = x_err;
            x.lat   = x_lat;
            x.wrs   = x_wrs;
            x.acc   = cyc;
            sb.push_back(x);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy !== 1'b0) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d completions still pending, busy=%b", sb.size(), busy);
        end
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        rstn = 1'b0; req = 1'b1; we = 1'b1; dmtype = `DM_WORD;
        addr = 32'h10; wdata = 32'hFFFF_FFFF; pc = 32'h1234_5678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy  !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done  !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err   !== 1'b0)  begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_cmp++; if (dm_wr !== 1'b0)  begin n_bad++; $display("FAIL reset_dm_wr: got %b want 0", dm_wr); end
        n_cmp++; if (dm_pc !== 32'd0) begin n_bad++; $display("FAIL reset_dm_pc: got %h want 0", dm_pc); end
        req  = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: busy %b want 0", busy); end
    endtask

    task automatic test_aligned();
        logic [31:0] w = 32'hA1B2_C3D4;
        issue(1'b1, `DM_WORD, 32'h10, w, 32'h0000_1000, 32'd0, 1'b0, 1, 1, 1'b1);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[8'h10 + 8'(i)] !== w[8*i +: 8]) begin
                n_bad++;
                $display("FAIL aligned_store_mem[%0d]: got %h want %h", i, mem[8'h10 + 8'(i)], w[8*i +: 8]);
            end
        end
        issue(1'b0, `DM_WORD,     32'h10, 32'd0, 32'h0000_1004, 32'hA1B2_C3D4, 1'b0, 1, 0, 1'b1);
        issue(1'b0, `DM_HALFWORD, 32'h12, 32'd0, 32'h0000_1008, 32'hFFFF_A1B2, 1'b0, 1, 0, 1'b1);
        issue(1'b1, `DM_BYTE,     32'h13, 32'h0000_00EE, 32'h0000_100C, 32'd0, 1'b0, 1, 1, 1'b1);
        issue(1'b0, `DM_BYTE_UNSIGNED, 32'h13, 32'd0, 32'h0000_1010, 32'h0000_00EE, 1'b0, 1, 0, 1'b1);
        wait_idle();
    endtask

    task automatic test_split_load();
        poke(8'h21, 8'h11); poke(8'h22, 8'h22); poke(8'h23, 8'h33); poke(8'h24, 8'h84);
        issue(1'b0, `DM_WORD, 32'h21, 32'd0, 32'h0000_2000,
              TRAP ? 32'd0 : 32'h8433_2211, TRAP, TRAP ? 0 : 4, 0, 1'b1);
        wait_idle();
    endtask

    task automatic test_halfword();
        poke(8'h23, 8'h00); poke(8'h24, 8'h80);
        issue(1'b0, `DM_HALFWORD, 32'h23, 32'd0, 32'h0000_3000,
              TRAP ? 32'd0 : 32'hFFFF_8000, TRAP, TRAP ? 0 : 2, 0, 1'b1);
        issue(1'b0, `DM_HALFWORD_UNSIGNED, 32'h23, 32'd0, 32'h0000_3004,
              TRAP ? 32'd0 : 32'h0000_8000, TRAP, TRAP ? 0 : 2, 0, 1'b1);
        issue(1'b0, `DM_BYTE,          32'h24, 32'd0, 32'h0000_3008, 32'hFFFF_FF80, 1'b0, 1, 0, 1'b1);
        issue(1'b0, `DM_BYTE_UNSIGNED, 32'h24, 32'd0, 32'h0000_300C, 32'h0000_0080, 1'b0, 1, 0, 1'b1);
        wait_idle();
    endtask

    task automatic test_wrap();
        poke(8'hFF, 8'h34); poke(8'h00, 8'h92);
        issue(1'b0, `DM_HALFWORD, 32'hFFFF_FFFF, 32'd0, 32'h0000_4000,
              TRAP ? 32'd0 : 32'hFFFF_9234, TRAP, TRAP ? 0 : 2, 0, 1'b1);
        wait_idle();
    endtask

    task automatic test_split_store();
        logic [31:0] exp_w;
        logic [15:0] exp_h;
        issue(1'b1, `DM_WORD, 32'h22, 32'h5A6B_7C8D, 32'h0000_5000,
              32'd0, TRAP, TRAP ? 0 : 4, TRAP ? 0 : 4, 1'b1);
        issue(1'b1, `DM_HALFWORD, 32'h61, 32'h0000_BEEF, 32'h0000_5004,
              32'd0, TRAP, TRAP ? 0 : 2, TRAP ? 0 : 2, 1'b1);
        wait_idle();
        exp_w = TRAP ? 32'h0080_0022 : 32'h5A6B_7C8D;
        exp_h = TRAP ? 16'h0000 : 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[8'h22 + 8'(i)] !== exp_w[8*i +: 8]) begin
                n_bad++;
                $display("FAIL split_store_mem[%0d]: got %h want %h", i, mem[8'h22 + 8'(i)], exp_w[8*i +: 8]);
            end
        end
        n_cmp++;
        if ({mem[8'h63], mem[8'h62], mem[8'h61], mem[8'h60]} !== {8'h00, exp_h, 8'h00}) begin
            n_bad++;
            $display("FAIL split_half_mem: got %h want %h",
                     {mem[8'h63], mem[8'h62], mem[8'h61], mem[8'h60]}, {8'h00, exp_h, 8'h00});
        end
    endtask

    task automatic test_unknown_type();
        issue(1'b1, 3'b110, 32'h70, 32'hFFFF_FFFF, 32'h0000_6000, 32'd0, 1'b1, 0, 0, 1'b1);
        issue(1'b0, 3'b111, 32'h70, 32'd0,         32'h0000_6004, 32'd0, 1'b1, 0, 0, 1'b1);
        wait_idle();
        n_cmp++;
        if (mem[8'h70] !== 8'h00) begin
            n_bad++;
            $display("FAIL unknown_type_mem: got %h want 00", mem[8'h70]);
        end
    endtask

    task automatic test_back_to_back();
        int          lat = TRAP ? 0 : 4;
        logic [31:0] exp_w = TRAP ? 32'd0 : 32'h0D0C_0B0A;
        issue(1'b1, `DM_WORD, 32'h31, 32'h0D0C_0B0A, 32'h0000_7000,
              32'd0, TRAP, lat, TRAP ? 0 : 4, 1'b1);
        // Hold a competing request through every busy edge, FINISH included.
        req = 1'b1; we = 1'b1; dmtype = `DM_WORD; addr = 32'h40;
        wdata = 32'hDEAD_BEEF; pc = 32'hBAD0_0000;
        repeat (lat + 1) @(posedge clk);
        #1;
        req = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} !== 32'd0) begin
            n_bad++;
            $display("FAIL busy_req_ignored: mem[0x40] got %h want 00000000",
                     {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]});
        end
        n_cmp++;
        if ({mem[8'h34], mem[8'h33], mem[8'h32], mem[8'h31]} !== exp_w) begin
            n_bad++;
            $display("FAIL b2b_store_mem: got %h want %h",
                     {mem[8'h34], mem[8'h33], mem[8'h32], mem[8'h31]}, exp_w);
        end
        issue(1'b1, `DM_WORD, 32'h44, 32'h1122_3344, 32'h0000_7004, 32'd0, 1'b0, 1, 1, 1'b1);
        issue(1'b0, `DM_WORD, 32'h44, 32'd0, 32'h0000_7008, 32'h1122_3344, 1'b0, 1, 0, 1'b1);
        wait_idle();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, `DM_WORD, 32'h51, 32'h4433_2211, 32'h0000_8000, 32'd0, 1'b0, 0, 0, 1'b0);
        @(posedge clk);          // beat 1 of 4 written
        #1;
        rstn = 1'b0;             // asserted while beat 2 of 4 is on the bus
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy  !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        n_cmp++; if (done  !== 1'b0) begin n_bad++; $display("FAIL mid_reset_done: got %b want 0", done); end
        n_cmp++; if (dm_wr !== 1'b0) begin n_bad++; $display("FAIL mid_reset_dm_wr: got %b want 0", dm_wr); end
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({mem[8'h54], mem[8'h53], mem[8'h52], mem[8'h51]} !== 32'h0000_2211) begin
            n_bad++;
            $display("FAIL mid_reset_mem: got %h want 00002211",
                     {mem[8'h54], mem[8'h53], mem[8'h52], mem[8'h51]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_aligned();
        test_split_load();
        test_halfword();
        test_wrap();
        test_split_store();
        test_unknown_type();
        test_back_to_back();
`ifndef MISALIGN_TRAP_EN
        test_reset_mid();
`endif
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d completions missing, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
